serial_addsub: RTL and testbench



---
 rtl/serial_addsub_pkg.sv | 24 ++
 rtl/serial_addsub_digit.sv | 28 ++
 rtl/serial_addsub.sv | 152 +++++++++++++++
 tb/tb_serial_addsub.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Step-counter width: clog2(steps), never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned steps);
      int unsigned w;
      if (steps <= 32'd1) begin
         w = 32'd1;
      end else begin
         w = $clog2(steps);
      end
      return w;
   endfunction

endpackage

// File: rtl/serial_addsub_digit.sv
// Combinational DIGIT_W-bit ripple adder built from full-adder slices.
module addsub_digit #(
   parameter int unsigned DIGIT_W = 1
) (
   input  logic [DIGIT_W-1:0] x,
   input  logic [DIGIT_W-1:0] y,
   input  logic               cin,
   output logic [DIGIT_W-1:0] s,
   output logic               cout,
   output logic               cmsb
);

   logic [DIGIT_W:0] w_c;

   assign w_c[0] = cin;

   for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
      logic w_p;
      assign w_p        = x[i] ^ y[i];
      assign s[i]       = w_p ^ w_c[i];
      assign w_c[i + 1] = (x[i] & y[i]) | (w_c[i] & w_p);
   end

   assign cout = w_c[DIGIT_W];
   // Carry into the top bit of this digit; on the last digit it is the word's MSB carry-in.
   assign cmsb = w_c[DIGIT_W - 1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor, LSB digit first, with start/busy/done handshake.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DIGIT_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned STEPS = WIDTH / DIGIT_W;
   localparam int unsigned CNT_W = cnt_width(STEPS);

   if (WIDTH < 2 || (WIDTH % DIGIT_W) != 0) begin : g_param_check
      $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT_W");
   end

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_load;
   logic               w_step;
   logic               w_last;

   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_cy;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_sr;
   logic [WIDTH-1:0]   r_result;
   logic               r_carry;
   logic               r_overflow;
   logic               r_zero;

   logic [DIGIT_W-1:0] w_s;
   logic               w_cout;
   logic               w_cmsb;
   logic [WIDTH-1:0]   w_sr_nxt;

   assign w_last = (r_cnt == CNT_W'(STEPS - 1));

   // State register plus registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ST_RUN);
         r_done  <= (w_state_nxt == ST_DONE);
      end
   end

   // Next-state logic; DONE accepts a new start so operations can run back to back.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_step = 1'b1;
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   addsub_digit #(
      .DIGIT_W (DIGIT_W)
   ) u_digit (
      .x    (r_a[DIGIT_W-1:0]),
      .y    (r_b[DIGIT_W-1:0]),
      .cin  (r_cy),
      .s    (w_s),
      .cout (w_cout),
      .cmsb (w_cmsb)
   );

   // New sum digit enters at the top; the shift also works when DIGIT_W == WIDTH.
   assign w_sr_nxt = WIDTH'({w_s, r_sr} >> DIGIT_W);

   // Operand/carry/counter datapath and result/flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a        <= '0;
         r_b        <= '0;
         r_cy       <= 1'b0;
         r_cnt      <= '0;
         r_sr       <= '0;
         r_result   <= '0;
         r_carry    <= 1'b0;
         r_overflow <= 1'b0;
         r_zero     <= 1'b1;
      end else if (w_load) begin
         r_a   <= a;
         r_b   <= (op_sub == OP_ADD) ? b : ~b;
         r_cy  <= (op_sub == OP_SUB);
         r_cnt <= '0;
         r_sr  <= '0;
      end else if (w_step) begin
         r_a   <= r_a >> DIGIT_W;
         r_b   <= r_b >> DIGIT_W;
         r_cy  <= w_cout;
         r_cnt <= r_cnt + CNT_W'(1);
         r_sr  <= w_sr_nxt;
         if (w_last) begin
            r_result   <= w_sr_nxt;
            r_carry    <= w_cout;
            r_overflow <= w_cout ^ w_cmsb;
            r_zero     <= (w_sr_nxt == '0);
         end
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign result   = r_result;
   assign carry    = r_carry;
   assign overflow = r_overflow;
   assign zero     = r_zero;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub across three WIDTH/DIGIT_W configurations.
module tb_serial_addsub;
   import serial_addsub_pkg::*;

   typedef struct {
      logic [7:0] res;
      logic       c;
      logic       v;
      logic       z;
      int         steps;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] st;
   logic       sub;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic [2:0] bz, dn, cy, ov, zr;
   logic [3:0] r0;
   logic [7:0] r1, r2;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(4), .DIGIT_W(1)) u_w4d1 (
      .clk(clk), .rst(rst), .start(st[0]), .op_sub(sub), .a(a_in[3:0]), .b(b_in[3:0]),
      .busy(bz[0]), .done(dn[0]), .result(r0), .carry(cy[0]), .overflow(ov[0]), .zero(zr[0]));

   serial_addsub #(.WIDTH(8), .DIGIT_W(4)) u_w8d4 (
      .clk(clk), .rst(rst), .start(st[1]), .op_sub(sub), .a(a_in), .b(b_in),
      .busy(bz[1]), .done(dn[1]), .result(r1), .carry(cy[1]), .overflow(ov[1]), .zero(zr[1]));

   serial_addsub #(.WIDTH(8), .DIGIT_W(8)) u_w8d8 (
      .clk(clk), .rst(rst), .start(st[2]), .op_sub(sub), .a(a_in), .b(b_in),
      .busy(bz[2]), .done(dn[2]), .result(r2), .carry(cy[2]), .overflow(ov[2]), .zero(zr[2]));

   function automatic int width_of(input int inst);
      return (inst == 0) ? 4 : 8;
   endfunction

   function automatic int steps_of(input int inst);
      return (inst == 0) ? 4 : ((inst == 1) ? 2 : 1);
   endfunction

   // Reference: integer arithmetic, overflow from operand/result signs.
   function automatic exp_t model(input int inst, input logic [7:0] a, input logic [7:0] b,
                                  input logic s);
      exp_t e;
      int   w    = width_of(inst);
      int   mask = (1 << w) - 1;
      int   av   = int'(a) & mask;
      int   bv   = (s ? ~int'(b) : int'(b)) & mask;
      int   sum  = av + bv + (s ? 1 : 0);
      int   rv   = sum & mask;
      int   sa   = (av >> (w - 1)) & 1;
      int   sbt  = (bv >> (w - 1)) & 1;
      int   sr   = (rv >> (w - 1)) & 1;
      e.res   = 8'(rv);
      e.c     = ((sum >> w) & 1) == 1;
      e.v     = (sa == sbt) && (sr != sa);
      e.z     = (rv == 0);
      e.steps = steps_of(inst);
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic get_obs(input int inst, output logic o_busy, output logic o_done,
                          output logic [7:0] o_res, output logic o_c, output logic o_v,
                          output logic o_z);
      o_busy = bz[inst];
      o_done = dn[inst];
      o_c    = cy[inst];
      o_v    = ov[inst];
      o_z    = zr[inst];
      case (inst)
         0:       o_res = {4'b0000, r0};
         1:       o_res = r1;
         default: o_res = r2;
      endcase
   endtask

   task automatic issue(input int inst, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input bit push);
      st       = '0;
      st[inst] = 1'b1;
      a_in     = a;
      b_in     = b;
      sub      = s;
      if (push) sb_q.push_back(model(inst, a, b, s));
   endtask

   // Runs until done is seen (bounded); optionally pulses an ignored start while busy.
   task automatic wait_done(input int inst, input int spurious_at, input string tag);
      int         cyc   = 0;
      int         nbusy = 0;
      bit         seen  = 0;
      logic       o_b, o_d, o_c, o_v, o_z;
      logic [7:0] o_r;
      exp_t       e;
      while (!seen && cyc < 40) begin
         @(posedge clk);
         #1;
         st = '0;
         cyc++;
         if (cyc == spurious_at) begin
            st[inst] = 1'b1;
            a_in     = 8'h09;
            b_in     = 8'h0C;
            sub      = ~sub;
         end
         get_obs(inst, o_b, o_d, o_r, o_c, o_v, o_z);
         if (o_b) nbusy++;
         if (o_d) seen = 1;
      end
      if (!seen) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
      end else if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_latency"}, 32'(cyc), 32'(e.steps + 1));
         check({tag, "_busy_cycles"}, 32'(nbusy), 32'(e.steps));
         check({tag, "_busy_in_done"}, 32'(o_b), 32'd0);
         check({tag, "_result"}, 32'(o_r), 32'(e.res));
         check({tag, "_carry"}, 32'(o_c), 32'(e.c));
         check({tag, "_overflow"}, 32'(o_v), 32'(e.v));
         check({tag, "_zero"}, 32'(o_z), 32'(e.z));
      end
   endtask

   // One idle cycle after done: pulse must have ended, result must hold.
   task automatic idle_tick(input int inst, input logic [7:0] hold_res, input string tag);
      logic       o_b, o_d, o_c, o_v, o_z;
      logic [7:0] o_r;
      @(posedge clk);
      #1;
      st = '0;
      get_obs(inst, o_b, o_d, o_r, o_c, o_v, o_z);
      check({tag, "_done_low"}, 32'(o_d), 32'd0);
      check({tag, "_idle_busy"}, 32'(o_b), 32'd0);
      check({tag, "_hold"}, 32'(o_r), 32'(hold_res));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       o_b, o_d, o_c, o_v, o_z;
      logic [7:0] o_r;
      int         pulses;

      rst  = 1'b1;
      st   = '0;
      sub  = OP_ADD;
      a_in = '0;
      b_in = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         get_obs(i, o_b, o_d, o_r, o_c, o_v, o_z);
         check($sformatf("reset%0d_busy", i), 32'(o_b), 32'd0);
         check($sformatf("reset%0d_done", i), 32'(o_d), 32'd0);
         check($sformatf("reset%0d_result", i), 32'(o_r), 32'd0);
         check($sformatf("reset%0d_carry", i), 32'(o_c), 32'd0);
         check($sformatf("reset%0d_ovf", i), 32'(o_v), 32'd0);
         check($sformatf("reset%0d_zero", i), 32'(o_z), 32'd1);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;

      // WIDTH=4, DIGIT_W=1 directed cases
      issue(0, 8'd7, 8'd3, OP_SUB, 1);  wait_done(0, -1, "sub_7_3");  idle_tick(0, 8'd4, "sub_7_3");
      issue(0, 8'd3, 8'd7, OP_SUB, 1);  wait_done(0, -1, "sub_3_7");  idle_tick(0, 8'hC, "sub_3_7");
      issue(0, 8'd7, 8'd1, OP_ADD, 1);  wait_done(0, -1, "add_7_1");  idle_tick(0, 8'h8, "add_7_1");
      issue(0, 8'd8, 8'd1, OP_SUB, 1);  wait_done(0, -1, "sub_8_1");  idle_tick(0, 8'h7, "sub_8_1");
      issue(0, 8'd5, 8'd5, OP_SUB, 1);  wait_done(0, -1, "sub_5_5");  idle_tick(0, 8'h0, "sub_5_5");
      issue(0, 8'd15, 8'd1, OP_ADD, 1); wait_done(0, -1, "add_15_1"); idle_tick(0, 8'h0, "add_15_1");

      // Wider digits: 2-step and 1-step operations
      issue(1, 8'h7F, 8'h01, OP_ADD, 1); wait_done(1, -1, "w8d4_add"); idle_tick(1, 8'h80, "w8d4_add");
      issue(2, 8'h7F, 8'h01, OP_ADD, 1); wait_done(2, -1, "w8d8_add"); idle_tick(2, 8'h80, "w8d8_add");
      issue(1, 8'h35, 8'hA7, OP_SUB, 1); wait_done(1, -1, "w8d4_sub"); idle_tick(1, 8'h8E, "w8d4_sub");
      issue(2, 8'h80, 8'h01, OP_SUB, 1); wait_done(2, -1, "w8d8_sub"); idle_tick(2, 8'h7F, "w8d8_sub");

      // Start while busy is ignored; start in DONE chains immediately
      issue(0, 8'd2, 8'd3, OP_ADD, 1); wait_done(0, 2, "ignore_busy");
      issue(0, 8'd6, 8'd9, OP_SUB, 1); wait_done(0, -1, "b2b_1");
      issue(0, 8'd4, 8'd4, OP_ADD, 1); wait_done(0, -1, "b2b_2");
      idle_tick(0, 8'h8, "b2b_2");

      // Reset during the second RUN cycle discards the operation
      issue(0, 8'd9, 8'd2, OP_ADD, 0);
      @(posedge clk); #1; st = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      get_obs(0, o_b, o_d, o_r, o_c, o_v, o_z);
      check("midrst_busy", 32'(o_b), 32'd0);
      check("midrst_done", 32'(o_d), 32'd0);
      check("midrst_result", 32'(o_r), 32'd0);
      check("midrst_zero", 32'(o_z), 32'd1);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (dn[0]) pulses++;
      end
      check("midrst_no_done", 32'(pulses), 32'd0);
      issue(0, 8'd9, 8'd2, OP_ADD, 1); wait_done(0, -1, "after_rst"); idle_tick(0, 8'hB, "after_rst");

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
